hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core; sits in ID and produces the bubble-select that drives the control-signal NOP mux feeding ID/EX.
- Generates PC/IF-ID/ID-EX/EX-MEM write enables and the IF/ID flush.
- Detects load-use and branch-operand hazards, including the two-bubble load-then-branch case.
- Freezes the pipeline on data-memory wait and keeps saturating stall statistics plus a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_if.sv | 17 +
 rtl/hazard_ctrl_sat_counter.sv | 16 +
 rtl/hazard_ctrl.sv | 43 ++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared register-field constants, FSM encoding and operand-match helper
//   REG_W    : register specifier width
//   REG_ZERO : hard-wired zero register, never a real dependency
//   state_t  : RUN (normal issue) / BUB2 (second bubble of load-then-branch)
package hazard_ctrl_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;
   typedef enum logic {RUN = 1'b0, BUB2 = 1'b1} state_t;
   function automatic logic hit(input logic [REG_W-1:0] r, rs, rt, input logic uses_rt);
      return (r != REG_ZERO) && (r == rs || (uses_rt && r == rt));
   endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard request and pipeline enable bundle
//   master : pipeline side, drives operand/EX/memory status, receives enables and statistics
//   slave  : hazard controller side
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int CNT_W = 16);
   logic [REG_W-1:0] id_rs, id_rt, ex_dest;
   logic id_uses_rt, id_branch, id_redirect, ex_mem_read, ex_reg_write, dmem_busy, stat_clr;
   logic pc_write, ifid_write, ifid_flush, nop_sel, idex_write, exmem_write, mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   modport master (
      output id_rs, id_rt, id_uses_rt, id_branch, id_redirect, ex_mem_read, ex_reg_write, ex_dest, dmem_busy, stat_clr,
      input  pc_write, ifid_write, ifid_flush, nop_sel, idex_write, exmem_write, stall_cycles, mem_timeout
   );
   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_branch, id_redirect, ex_mem_read, ex_reg_write, ex_dest, dmem_busy, stat_clr,
      output pc_write, ifid_write, ifid_flush, nop_sel, idex_write, exmem_write, stall_cycles, mem_timeout
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// hazard_ctrl_sat_counter: saturating up-counter with synchronous clear
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, clr   : count enable, clear (clear wins)
//   q          : count value, sticks at all-ones
module hazard_ctrl_sat_counter #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage load-use/branch hazard control, memory freeze and stall statistics
//   clk, rst_n : clock, asynchronous active-low reset
//   hz         : hazard_ctrl_if slave - operand/EX/memory status in, pipeline enables,
//                NOP-mux select, IF/ID flush, stall_cycles and sticky mem_timeout out
module hazard_ctrl import hazard_ctrl_pkg::*; #(
   parameter int CNT_W        = 16,
   parameter int MAX_MEM_WAIT = 64
) (
   input logic         clk,
   input logic         rst_n,
   hazard_ctrl_if.slave hz
);
   localparam logic [7:0] LAST_WAIT = 8'(MAX_MEM_WAIT - 1);
   state_t     state;
   logic       hazard, bubble, freeze;
   logic [7:0] wait_cnt;
   assign hazard = hit(hz.ex_dest, hz.id_rs, hz.id_rt, hz.id_uses_rt) &&
                   (hz.ex_mem_read || (hz.id_branch && hz.ex_reg_write));
   assign freeze = hz.dmem_busy;
   assign bubble = !freeze && (state == BUB2 || hazard);
   // reset forces the pipeline quiet and injects a NOP/flush until release
   assign hz.pc_write    = rst_n && !freeze && !bubble;
   assign hz.ifid_write  = rst_n && !freeze && !bubble;
   assign hz.idex_write  = rst_n && !freeze;
   assign hz.exmem_write = rst_n && !freeze;
   assign hz.nop_sel     = !rst_n || bubble;
   // redirect only counts once operands are valid, i.e. no stall or freeze
   assign hz.ifid_flush  = !rst_n || (!freeze && !bubble && hz.id_redirect);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= RUN;
         hz.mem_timeout <= 1'b0;
      end else begin
         state          <= freeze ? state : (state == RUN && hazard && hz.id_branch && hz.ex_mem_read) ? BUB2 : RUN;
         hz.mem_timeout <= hz.mem_timeout || (hz.dmem_busy && wait_cnt >= LAST_WAIT);
      end
   hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall (
      .clk(clk), .rst_n(rst_n), .inc(!hz.pc_write), .clr(hz.stat_clr), .q(hz.stall_cycles)
   );
   hazard_ctrl_sat_counter #(.W(8)) u_wait (
      .clk(clk), .rst_n(rst_n), .inc(hz.dmem_busy), .clr(!hz.dmem_busy), .q(wait_cnt)
   );
endmodule
